// File: rtl/mini_pkg.sv
// Shared Mini DPLL solver package: decision-stack entry layout and backtrack FSM states.
package mini_pkg;

  localparam int unsigned MAX_VARS     = 256;
  localparam int unsigned DSTACK_VAR_W = $clog2(MAX_VARS);

  typedef struct packed {
    logic [DSTACK_VAR_W-1:0] var_idx;
    logic                    first_pol;
    logic                    tried_pos;
    logic                    tried_neg;
  } dstack_entry_t;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_SCAN,
    DS_DONE
  } dstack_state_t;

endpackage

// File: rtl/mini_decision_stack_if.sv
// Solver-side bus of the decision stack. MINI_DSTACK_STATS_EN adds the statistics outputs.
interface mini_decision_stack_if #(
  parameter int unsigned VAR_W   = 8,
  parameter int unsigned LEVEL_W = 16
);

  logic               clear;
  logic               push_valid;
  logic [VAR_W-1:0]   push_var;
  logic               push_pol;
  logic               push_ready;
  logic               bt_req;
  logic               bt_busy;
  logic               bt_done;
  logic               bt_found;
  logic [VAR_W-1:0]   bt_var;
  logic               bt_pol;
  logic [LEVEL_W-1:0] bt_level;
  logic               unassign_valid;
  logic [VAR_W-1:0]   unassign_var;
  logic [LEVEL_W-1:0] level;
  logic               full;
  logic               empty;
  logic               overflow;
`ifdef MINI_DSTACK_STATS_EN
  logic [31:0]        stat_bt_count;
  logic [LEVEL_W-1:0] stat_max_depth;
`endif

  modport master (
    output clear, push_valid, push_var, push_pol, bt_req,
    input  push_ready, bt_busy, bt_done, bt_found, bt_var, bt_pol, bt_level,
           unassign_valid, unassign_var, level, full, empty, overflow
`ifdef MINI_DSTACK_STATS_EN
    , input stat_bt_count, stat_max_depth
`endif
  );

  modport slave (
    input  clear, push_valid, push_var, push_pol, bt_req,
    output push_ready, bt_busy, bt_done, bt_found, bt_var, bt_pol, bt_level,
           unassign_valid, unassign_var, level, full, empty, overflow
`ifdef MINI_DSTACK_STATS_EN
    , output stat_bt_count, stat_max_depth
`endif
  );

endinterface

// File: rtl/mini_dstack_regfile.sv
// Decision entry array: one push write port, a top-of-stack read and a tried-flag update port.
module mini_dstack_regfile #(
  parameter int unsigned VAR_W = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [VAR_W-1:0] i_wr_var,
  input  logic             i_wr_pol,
  input  logic [IDX_W-1:0] i_top_idx,
  output logic [VAR_W-1:0] o_top_var,
  output logic             o_top_pol,
  output logic             o_top_pos,
  output logic             o_top_neg,
  input  logic             i_flag_en,
  input  logic             i_set_pos,
  input  logic             i_set_neg
);

  logic [VAR_W-1:0] r_var [DEPTH];
  logic             r_pol [DEPTH];
  logic             r_pos [DEPTH];
  logic             r_neg [DEPTH];

  // Storage needs no reset: slots above the current level are never read.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_var[i_wr_idx] <= i_wr_var;
      r_pol[i_wr_idx] <= i_wr_pol;
      r_pos[i_wr_idx] <= i_wr_pol;
      r_neg[i_wr_idx] <= ~i_wr_pol;
    end
    if (i_flag_en) begin
      if (i_set_pos) r_pos[i_top_idx] <= 1'b1;
      if (i_set_neg) r_neg[i_top_idx] <= 1'b1;
    end
  end

  assign o_top_var = r_var[i_top_idx];
  assign o_top_pol = r_pol[i_top_idx];
  assign o_top_pos = r_pos[i_top_idx];
  assign o_top_neg = r_neg[i_top_idx];

endmodule

// File: rtl/mini_decision_stack.sv
// Decision trail with autonomous chronological backtrack for the Mini DPLL solver.
// Optional statistics outputs are enabled by defining MINI_DSTACK_STATS_EN.
module mini_decision_stack
  import mini_pkg::*;
#(
  parameter int unsigned VAR_W   = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LEVEL_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  mini_decision_stack_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dstack_state_t      r_state_q, w_state_d;
  logic [LEVEL_W-1:0] r_level_q, w_level_d;
  logic               r_overflow_q, w_overflow_d;
  logic               r_found_q, w_found_d;
  logic [VAR_W-1:0]   r_bt_var_q, w_bt_var_d;
  logic               r_bt_pol_q, w_bt_pol_d;
  logic [LEVEL_W-1:0] r_bt_level_q, w_bt_level_d;

  logic               w_full, w_empty, w_push_ready, w_push_fire;
  logic               w_flag_en, w_unassign, w_done;
  logic [LEVEL_W-1:0] w_level_m1;
  logic [VAR_W-1:0]   w_top_var;
  logic               w_top_pol, w_top_pos, w_top_neg;

  assign w_full       = (r_level_q == LEVEL_W'(DEPTH));
  assign w_empty      = (r_level_q == '0);
  assign w_level_m1   = r_level_q - LEVEL_W'(1);
  assign w_push_ready = (r_state_q == DS_IDLE) && !w_full && !bus.bt_req;
  assign w_push_fire  = bus.push_valid && w_push_ready && !bus.clear;
  assign w_done       = (r_state_q == DS_DONE) && !bus.clear;

  mini_dstack_regfile #(
    .VAR_W (VAR_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk       (clk),
    .i_wr_en   (w_push_fire),
    .i_wr_idx  (r_level_q[IDX_W-1:0]),
    .i_wr_var  (bus.push_var),
    .i_wr_pol  (bus.push_pol),
    .i_top_idx (w_level_m1[IDX_W-1:0]),
    .o_top_var (w_top_var),
    .o_top_pol (w_top_pol),
    .o_top_pos (w_top_pos),
    .o_top_neg (w_top_neg),
    .i_flag_en (w_flag_en),
    .i_set_pos (~w_top_pol),
    .i_set_neg (w_top_pol)
  );

  always_comb begin
    w_state_d    = r_state_q;
    w_level_d    = r_level_q;
    w_found_d    = r_found_q;
    w_bt_var_d   = r_bt_var_q;
    w_bt_pol_d   = r_bt_pol_q;
    w_bt_level_d = r_bt_level_q;
    w_flag_en    = 1'b0;
    w_unassign   = 1'b0;
    w_overflow_d = r_overflow_q | (bus.push_valid && w_full && (r_state_q == DS_IDLE));
    unique case (r_state_q)
      DS_IDLE: begin
        if (bus.bt_req)   w_state_d = DS_SCAN;
        else if (w_push_fire) w_level_d = r_level_q + LEVEL_W'(1);
      end
      DS_SCAN: begin
        if (w_empty) begin
          w_found_d = 1'b0;
          w_state_d = DS_DONE;
        end else if (w_top_pos && w_top_neg) begin
          w_unassign = 1'b1;
          w_level_d  = w_level_m1;
        end else begin
          // Both polarities are now tried, so a later backtrack pops this entry.
          w_flag_en    = 1'b1;
          w_bt_var_d   = w_top_var;
          w_bt_pol_d   = ~w_top_pol;
          w_bt_level_d = r_level_q;
          w_found_d    = 1'b1;
          w_state_d    = DS_DONE;
        end
      end
      DS_DONE: w_state_d = DS_IDLE;
      default: w_state_d = DS_IDLE;
    endcase
    if (bus.clear) begin
      w_state_d    = DS_IDLE;
      w_level_d    = '0;
      w_overflow_d = 1'b0;
      w_flag_en    = 1'b0;
      w_unassign   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q    <= DS_IDLE;
      r_level_q    <= '0;
      r_overflow_q <= 1'b0;
      r_found_q    <= 1'b0;
      r_bt_var_q   <= '0;
      r_bt_pol_q   <= 1'b0;
      r_bt_level_q <= '0;
    end else begin
      r_state_q    <= w_state_d;
      r_level_q    <= w_level_d;
      r_overflow_q <= w_overflow_d;
      r_found_q    <= w_found_d;
      r_bt_var_q   <= w_bt_var_d;
      r_bt_pol_q   <= w_bt_pol_d;
      r_bt_level_q <= w_bt_level_d;
    end
  end

  assign bus.push_ready     = w_push_ready;
  assign bus.bt_busy        = (r_state_q != DS_IDLE);
  assign bus.bt_done        = w_done;
  assign bus.bt_found       = r_found_q;
  assign bus.bt_var         = r_bt_var_q;
  assign bus.bt_pol         = r_bt_pol_q;
  assign bus.bt_level       = r_bt_level_q;
  assign bus.unassign_valid = w_unassign;
  assign bus.unassign_var   = w_unassign ? w_top_var : '0;
  assign bus.level          = r_level_q;
  assign bus.full           = w_full;
  assign bus.empty          = w_empty;
  assign bus.overflow       = r_overflow_q;

`ifdef MINI_DSTACK_STATS_EN
  logic [31:0]        r_stat_cnt_q;
  logic [LEVEL_W-1:0] r_stat_max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_cnt_q <= '0;
      r_stat_max_q <= '0;
    end else if (bus.clear) begin
      r_stat_cnt_q <= '0;
      r_stat_max_q <= '0;
    end else begin
      if (w_done && (r_stat_cnt_q != '1)) r_stat_cnt_q <= r_stat_cnt_q + 32'd1;
      if (r_level_q > r_stat_max_q)       r_stat_max_q <= r_level_q;
    end
  end

  assign bus.stat_bt_count  = r_stat_cnt_q;
  assign bus.stat_max_depth = r_stat_max_q;
`endif

endmodule

// File: tb/tb_mini_decision_stack.sv
// Directed self-checking bench for mini_decision_stack (small DEPTH to exercise full/overflow).
module tb_mini_decision_stack;

  localparam int unsigned VAR_W   = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned LEVEL_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  mini_decision_stack_if #(.VAR_W(VAR_W), .LEVEL_W(LEVEL_W)) bus ();

  mini_decision_stack #(
    .VAR_W   (VAR_W),
    .DEPTH   (DEPTH),
    .LEVEL_W (LEVEL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [VAR_W-1:0] v, input logic p);
    bus.push_var   = v;
    bus.push_pol   = p;
    bus.push_valid = 1'b1;
    step();
    bus.push_valid = 1'b0;
  endtask

  task automatic bt_pulse();
    bus.bt_req = 1'b1;
    step();
    bus.bt_req = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.clear      = 1'b0;
    bus.push_valid = 1'b0;
    bus.push_var   = '0;
    bus.push_pol   = 1'b0;
    bus.bt_req     = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty",      32'(bus.empty), 32'd1);
    check("rst_push_ready", 32'(bus.push_ready), 32'd1);
    check("rst_level",      32'(bus.level), 32'd0);
    check("rst_misc",       32'({bus.bt_busy, bus.bt_done, bus.bt_found, bus.full,
                                 bus.overflow, bus.unassign_valid}), 32'd0);
    rst_n = 1'b1;
    step();

    // Three decisions, first backtrack flips the top one in place
    push(8'd3, 1'b1);
    push(8'd7, 1'b0);
    push(8'd9, 1'b1);
    check("t1_level", 32'(bus.level), 32'd3);
    bt_pulse();
    check("t1_busy",     32'(bus.bt_busy), 32'd1);
    check("t1_no_unasg", 32'(bus.unassign_valid), 32'd0);
    step();
    check("t1_done",   32'(bus.bt_done), 32'd1);
    check("t1_found",  32'(bus.bt_found), 32'd1);
    check("t1_var",    32'(bus.bt_var), 32'd9);
    check("t1_pol",    32'(bus.bt_pol), 32'd0);
    check("t1_btlvl",  32'(bus.bt_level), 32'd3);
    check("t1_level2", 32'(bus.level), 32'd3);
    step();
    check("t1_done_pulse", 32'(bus.bt_done), 32'd0);
    check("t1_hold_var",   32'(bus.bt_var), 32'd9);

    // Second backtrack pops 9 then flips 7
    bt_pulse();
    check("t2_unasg_v", 32'(bus.unassign_valid), 32'd1);
    check("t2_unasg",   32'(bus.unassign_var), 32'd9);
    step();
    check("t2_not_yet", 32'(bus.bt_done), 32'd0);
    check("t2_level",   32'(bus.level), 32'd2);
    step();
    check("t2_done",  32'(bus.bt_done), 32'd1);
    check("t2_var",   32'(bus.bt_var), 32'd7);
    check("t2_pol",   32'(bus.bt_pol), 32'd1);
    check("t2_btlvl", 32'(bus.bt_level), 32'd2);
    step();

    do_clear();
    check("clr_level", 32'(bus.level), 32'd0);
    check("clr_empty", 32'(bus.empty), 32'd1);

    // Single entry: flip, then exhaust
    push(8'd5, 1'b1);
    bt_pulse();
    step();
    check("t3_done",  32'(bus.bt_done), 32'd1);
    check("t3_found", 32'(bus.bt_found), 32'd1);
    check("t3_var",   32'(bus.bt_var), 32'd5);
    check("t3_pol",   32'(bus.bt_pol), 32'd0);
    step();
    bt_pulse();
    check("t3_unasg", 32'({bus.unassign_valid, bus.unassign_var}), 32'h105);
    step();
    step();
    check("t3_done2",  32'(bus.bt_done), 32'd1);
    check("t3_unsat",  32'(bus.bt_found), 32'd0);
    check("t3_level",  32'(bus.level), 32'd0);
    check("t3_empty",  32'(bus.empty), 32'd1);
    step();

    // Fill, overflow, clear
    for (int i = 0; i < int'(DEPTH); i++) push(8'(i + 20), i[0]);
    check("t4_full",     32'(bus.full), 32'd1);
    check("t4_level",    32'(bus.level), 32'(DEPTH));
    check("t4_ready",    32'(bus.push_ready), 32'd0);
    check("t4_ovf_pre",  32'(bus.overflow), 32'd0);
    push(8'd99, 1'b1);
    check("t4_ovf",      32'(bus.overflow), 32'd1);
    check("t4_level2",   32'(bus.level), 32'(DEPTH));
    do_clear();
    check("t4_clr", 32'({bus.level, bus.overflow, bus.empty, bus.full}), 32'b0000_0_1_0);

    // Same-cycle push and bt_req: backtrack wins
    push(8'd4, 1'b1);
    bus.push_var   = 8'd6;
    bus.push_pol   = 1'b1;
    bus.push_valid = 1'b1;
    bus.bt_req     = 1'b1;
    #1;
    check("t5_ready_req", 32'(bus.push_ready), 32'd0);
    step();
    bus.bt_req = 1'b0;
    check("t5_busy",  32'(bus.bt_busy), 32'd1);
    check("t5_ready", 32'(bus.push_ready), 32'd0);
    step();
    check("t5_done",  32'(bus.bt_done), 32'd1);
    check("t5_var",   32'(bus.bt_var), 32'd4);
    check("t5_pol",   32'(bus.bt_pol), 32'd0);
    check("t5_btlvl", 32'(bus.bt_level), 32'd1);
    bus.push_valid = 1'b0;
    step();
    check("t5_level", 32'(bus.level), 32'd1);

    // Async reset mid-scan
    do_clear();
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b1);
    bt_pulse();
    check("t6_busy", 32'(bus.bt_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_level", 32'(bus.level), 32'd0);
    check("t6_idle",  32'({bus.bt_busy, bus.bt_done, bus.empty}), 32'b001);
    step();
    check("t6_hold",  32'(bus.bt_done), 32'd0);
    rst_n = 1'b1;
    step();
    push(8'd11, 1'b1);
    check("t6_push", 32'({bus.level, bus.empty}), 32'b0001_0);
`ifdef MINI_DSTACK_STATS_EN
    step();
    check("st_cnt", bus.stat_bt_count, 32'd0);
    check("st_max", 32'(bus.stat_max_depth), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mini_decision_stack.md
Name: mini_decision_stack

Overview:
- Parametrised hardware decision trail for the Mini DPLL solver. It is the next generation of the single decision-entry record.
- Holds up to DEPTH decision entries (variable, first polarity, tried flags) and performs chronological backtrack autonomously: it pops exhausted decisions one per cycle and returns the next decision to flip.
- Sits beside the main solver FSM; the CONFLICT/BACKTRACK/FLIP_DECISION states drive it. Implied (propagated) literals are tracked elsewhere.

Parameters:
- VAR_W, 8, variable-index width (log2 of the variable count).
- DEPTH, 256, maximum number of stacked decisions.
- LEVEL_W, 16, width of depth/level outputs; must satisfy 2^LEVEL_W > DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush to empty.
- push_valid  in  1  record a new decision.
- push_var  in  VAR_W  decided variable.
- push_pol  in  1  first polarity tried (1 = positive).
- push_ready  out  1  push accepted this cycle when high.
- bt_req  in  1  start backtrack (1-cycle pulse).
- bt_busy  out  1  backtrack in progress.
- bt_done  out  1  1-cycle completion pulse.
- bt_found  out  1  valid with bt_done; 1 = flip available, 0 = stack exhausted (UNSAT).
- bt_var  out  VAR_W  variable to flip.
- bt_pol  out  1  polarity to assign now.
- bt_level  out  LEVEL_W  decision level after the flip.
- unassign_valid  out  1  one popped decision this cycle.
- unassign_var  out  VAR_W  variable to unassign.
- level  out  LEVEL_W  current stack depth.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky; set when a push is attempted while full.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, level 0, overflow 0. All outputs are 0, except empty = 1 and push_ready = 1.
- Each entry holds {var, first_pol, tried_pos, tried_neg}.
- Push: push_ready = (state==IDLE) && !full && !bt_req. On push_valid && push_ready:
  - write entry[level] with the tried flag matching push_pol set;
  - level increments next cycle.
- Push while full: dropped, overflow set. Push while not in IDLE: dropped silently.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: bt_req goes to SCAN and bt_busy is 1 from the next cycle. bt_req wins over a same-cycle push.
  - SCAN, level == 0: bt_found = 0, go to DONE.
  - SCAN, top entry has both tried flags set: pop it; unassign_valid = 1 with unassign_var = its var in that cycle; level decrements; stay in SCAN.
  - SCAN, otherwise: set the untried flag on the top entry; bt_var = top var, bt_pol = ~first_pol, bt_level = level, bt_found = 1; go to DONE. The entry stays on the stack.
  - DONE: bt_done = 1 for one cycle; bt_var/bt_pol/bt_level/bt_found stay valid and hold until the next bt_req. Then return to IDLE.
- Latency: with k exhausted entries on top, bt_done asserts k+2 cycles after the bt_req edge.
- bt_req while busy: ignored.
- clear: highest priority in any state.
  - level 0, state IDLE, overflow 0, no bt_done.
  - unassign_valid is not emitted for flushed entries; the solver clears its assignments separately.
- Arithmetic: level never wraps; push at DEPTH and pop at 0 are both impossible by construction.

Optional Feature:
- MINI_DSTACK_STATS_EN defined: adds outputs stat_bt_count (32 bits, increments on each bt_done, saturating) and stat_max_depth (LEVEL_W bits, high-water mark of level). Both reset to 0 on rst_n and on clear.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mini_pkg gains:
  - constant DSTACK_VAR_W = $clog2(MAX_VARS);
  - typedef dstack_entry_t, a packed {var, first_pol, tried_pos, tried_neg};
  - enum dstack_state_t {DS_IDLE, DS_SCAN, DS_DONE}.
- Natural sub-module: mini_dstack_regfile, the entry array with one write port, a top-of-stack read, and a flag-update port.

Test Plan:
- Push vars 3(+), 7(-), 9(+); bt_req → no unassign; bt_done 2 cycles later with found=1, var=9, pol=0, level=3; level stays 3.
- Repeat bt_req from that state → unassign 9 in cycle 1, then done with var=7, pol=1, level=2; total latency 3 cycles.
- Single entry var 5(+), two bt_reqs → first returns var 5, pol 0. Second pops 5, then bt_done with found=0, and level/empty read 0/1.
- Fill DEPTH entries, then push once more → full=1, overflow=1, level stays DEPTH. Then clear → level 0, overflow 0, empty 1.
- push_valid and bt_req in the same IDLE cycle with 1 entry → push dropped, backtrack proceeds on the original entry; bt_busy blocks pushes until bt_done.
- Assert rst_n low mid-SCAN with 4 entries → level 0 immediately, no bt_done; a push after release is accepted.
